// File: rtl/stage3_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages and stage3_hazard_ctrl.
// slave: the hazard controller (status in, controls out); master: the pipeline side.
interface stage3_hazard_ctrl_if;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_m;
    logic        reg_write;
    logic        dren;
    logic        dwen;
    logic        csr_read;
    logic        valid_e;
    logic        valid_m;
    logic        i_mem_busy;
    logic        d_mem_busy;
    logic        ex_busy;
    logic        fence_stall;
    logic        mispredict;
    logic        mret;
    logic        sret;
    logic        ifence;
    logic        sfence;
    logic        wfi;
    logic        halt;
    logic        exc_m;
    logic        intr_pending;
    logic [31:0] trap_target;

    logic        pc_en;
    logic        npc_sel;
    logic        if_ex_flush;
    logic        ex_mem_flush;
    logic        if_ex_stall;
    logic        ex_mem_stall;
    logic        iren;
    logic        suppress_iren;
    logic        suppress_data;
    logic        rollback;
    logic        mem_use_stall;
    logic        insert_priv_pc;
    logic [31:0] priv_pc;
    logic        trap_commit;
    logic        in_wfi;

    modport slave (
        input  rs1_e, rs2_e, rd_m, reg_write, dren, dwen, csr_read,
        input  valid_e, valid_m, i_mem_busy, d_mem_busy, ex_busy,
        input  fence_stall, mispredict, mret, sret, ifence, sfence,
        input  wfi, halt, exc_m, intr_pending, trap_target,
        output pc_en, npc_sel, if_ex_flush, ex_mem_flush,
        output if_ex_stall, ex_mem_stall, iren, suppress_iren,
        output suppress_data, rollback, mem_use_stall,
        output insert_priv_pc, priv_pc, trap_commit, in_wfi
    );

    modport master (
        output rs1_e, rs2_e, rd_m, reg_write, dren, dwen, csr_read,
        output valid_e, valid_m, i_mem_busy, d_mem_busy, ex_busy,
        output fence_stall, mispredict, mret, sret, ifence, sfence,
        output wfi, halt, exc_m, intr_pending, trap_target,
        input  pc_en, npc_sel, if_ex_flush, ex_mem_flush,
        input  if_ex_stall, ex_mem_stall, iren, suppress_iren,
        input  suppress_data, rollback, mem_use_stall,
        input  insert_priv_pc, priv_pc, trap_commit, in_wfi
    );
endinterface

// File: rtl/stage3_hazard_ctrl.sv
// Hazard control for the 3-stage pipeline: stalls, flushes, trap/WFI/halt/rollback FSM.
// Ports: CLK, nRST (async active-low), hz (stage3_hazard_ctrl_if.slave).
module stage3_hazard_ctrl #(
    parameter bit WFI_EN      = 1'b1,
    parameter bit ROLLBACK_EN = 1'b1
) (
    input logic                 CLK,
    input logic                 nRST,
    stage3_hazard_ctrl_if.slave hz
);
    typedef enum logic [2:0] {
        S_RUN, S_DRAIN, S_TRAP, S_WFI, S_HALTED
    } state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_priv_pc, w_priv_pc_n;
    logic        r_rb_pend, w_rb_pend_n;

    logic w_mem_busy, w_ems, w_ies, w_mus;
    logic w_trap_req, w_rb_req, w_halt_r, w_wfi_r, w_mp_r, w_rb_fire;

    always_comb begin
        w_mem_busy = hz.d_mem_busy & (hz.dren | hz.dwen);
        w_mus      = hz.valid_e & hz.valid_m & hz.dren & hz.d_mem_busy
                   & (hz.rd_m != 5'd0)
                   & ((hz.rd_m == hz.rs1_e) | (hz.rd_m == hz.rs2_e));
        w_ems      = w_mem_busy | hz.fence_stall;
        w_ies      = w_ems | hz.ex_busy | w_mus | hz.i_mem_busy;
        w_trap_req = hz.valid_m
                   & (hz.exc_m | hz.intr_pending | hz.mret | hz.sret);
        w_rb_req   = ROLLBACK_EN & hz.valid_m
                   & (hz.ifence | hz.sfence | hz.csr_read);
        w_halt_r   = hz.halt & hz.valid_m;
        w_wfi_r    = WFI_EN & hz.wfi & hz.valid_m & ~hz.intr_pending;
        w_mp_r     = hz.mispredict & hz.valid_m;
        // A pending refetch yields to halt and to any trap request.
        w_rb_fire  = r_rb_pend & ~hz.i_mem_busy & ~w_halt_r & ~w_trap_req;
    end

    always_comb begin
        w_state_n          = r_state;
        w_priv_pc_n        = r_priv_pc;
        w_rb_pend_n        = r_rb_pend;
        hz.pc_en           = 1'b0;
        hz.npc_sel         = 1'b0;
        hz.if_ex_flush     = 1'b0;
        hz.ex_mem_flush    = 1'b0;
        hz.if_ex_stall     = 1'b0;
        hz.ex_mem_stall    = 1'b0;
        hz.iren            = 1'b1;
        hz.suppress_iren   = 1'b0;
        hz.rollback        = 1'b0;
        hz.insert_priv_pc  = 1'b0;
        hz.trap_commit     = 1'b0;
        hz.in_wfi          = 1'b0;
        hz.suppress_data   = hz.valid_m & hz.exc_m;
        hz.mem_use_stall   = w_mus;
        hz.priv_pc         = r_priv_pc;

        unique case (r_state)
            S_RUN: begin
                hz.if_ex_stall  = w_ies;
                hz.ex_mem_stall = w_ems;
                hz.pc_en        = ~w_ies;
                if (w_rb_fire) begin
                    hz.rollback    = 1'b1;
                    hz.if_ex_flush = 1'b1;
                    hz.pc_en       = 1'b1;
                    w_rb_pend_n    = 1'b0;
                end
                if (w_halt_r) begin
                    w_state_n = S_HALTED;
                end else if (w_trap_req) begin
                    // Trap waits while mem holds the stage stalled.
                    if (!w_mem_busy) begin
                        w_priv_pc_n = hz.trap_target;
                        w_state_n   = hz.i_mem_busy ? S_DRAIN : S_TRAP;
                    end
                end else if (w_wfi_r) begin
                    w_state_n = S_WFI;
                end else if (w_rb_req) begin
                    w_rb_pend_n = 1'b1;
                end else if (w_mp_r && !w_mem_busy) begin
                    hz.npc_sel      = 1'b1;
                    hz.if_ex_flush  = 1'b1;
                    hz.ex_mem_flush = 1'b1;
                    hz.pc_en        = ~hz.i_mem_busy;
                end
                // Flush wins over stall on the same register.
                if (hz.if_ex_flush)  hz.if_ex_stall  = 1'b0;
                if (hz.ex_mem_flush) hz.ex_mem_stall = 1'b0;
            end
            S_DRAIN: begin
                hz.suppress_iren = 1'b1;
                hz.iren          = 1'b0;
                hz.if_ex_stall   = 1'b1;
                hz.ex_mem_stall  = 1'b1;
                if (!hz.i_mem_busy) w_state_n = S_TRAP;
            end
            S_TRAP: begin
                hz.insert_priv_pc = 1'b1;
                hz.pc_en          = 1'b1;
                hz.if_ex_flush    = 1'b1;
                hz.ex_mem_flush   = 1'b1;
                hz.trap_commit    = 1'b1;
                w_rb_pend_n       = 1'b0;
                w_state_n         = S_RUN;
            end
            S_WFI: begin
                hz.in_wfi       = 1'b1;
                hz.iren         = 1'b0;
                hz.if_ex_stall  = 1'b1;
                hz.ex_mem_stall = 1'b1;
                // Fetch is idle while sleeping, so no drain is needed.
                if (hz.intr_pending) begin
                    w_priv_pc_n = hz.trap_target;
                    w_state_n   = S_TRAP;
                end
            end
            S_HALTED: begin
                hz.iren         = 1'b0;
                hz.if_ex_stall  = 1'b1;
                hz.ex_mem_stall = 1'b1;
            end
            default: w_state_n = S_RUN;
        endcase

        if (!nRST) begin
            hz.pc_en           = 1'b1;
            hz.npc_sel         = 1'b0;
            hz.if_ex_flush     = 1'b0;
            hz.ex_mem_flush    = 1'b0;
            hz.if_ex_stall     = 1'b0;
            hz.ex_mem_stall    = 1'b0;
            hz.iren            = 1'b1;
            hz.suppress_iren   = 1'b0;
            hz.suppress_data   = 1'b0;
            hz.rollback        = 1'b0;
            hz.mem_use_stall   = 1'b0;
            hz.insert_priv_pc  = 1'b0;
            hz.trap_commit     = 1'b0;
            hz.in_wfi          = 1'b0;
            hz.priv_pc         = 32'd0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_RUN;
            r_priv_pc <= 32'd0;
            r_rb_pend <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_priv_pc <= w_priv_pc_n;
            r_rb_pend <= w_rb_pend_n;
        end
    end
endmodule

// File: doc/stage3_hazard_ctrl.md
Name: stage3_hazard_ctrl

Overview:
- Control end of the three-stage pipeline hazard interface.
- Consumes execute/mem status and exception signals; produces all stall, flush, PC-enable, fetch-suppress and privileged-redirect controls.
- Sequences trap entry, mret/sret return, WFI sleep, rollback (ifence/sfence/CSR) and halt through a registered FSM.
- Sits between the fetch, execute and mem stages and the privilege unit.

Parameters:
- WFI_EN, 1, 1 = WFI enters the sleep state; 0 = WFI is treated as a NOP.
- ROLLBACK_EN, 1, 1 = ifence/sfence/CSR-read in mem triggers a rollback refetch.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- rs1_e, rs2_e  in  5 each  source registers in execute
- rd_m  in  5  destination register in mem
- reg_write, dren, dwen, csr_read  in  1 each  mem-stage instruction attributes
- valid_e, valid_m  in  1 each  stage holds a real instruction
- i_mem_busy, d_mem_busy, ex_busy, fence_stall  in  1 each  busy indications
- mispredict, mret, sret, ifence, sfence, wfi, halt  in  1 each  mem-stage events
- exc_m  in  1  OR of all mem-stage fault, misaligned, illegal, breakpoint, env and page faults
- intr_pending  in  1  enabled interrupt pending, from the privilege unit
- trap_target  in  32  xTVEC or xEPC target, from the privilege unit
- pc_en, npc_sel  out  1 each  PC update enable; select mem-computed next PC
- if_ex_flush, ex_mem_flush, if_ex_stall, ex_mem_stall  out  1 each  pipeline register controls
- iren, suppress_iren, suppress_data  out  1 each  fetch enable; squash fetch; squash mem access
- rollback, mem_use_stall  out  1 each  refetch from pc_m+4; load-use stall
- insert_priv_pc  out  1  redirect fetch to priv_pc
- priv_pc  out  32  registered redirect target
- trap_commit  out  1  one-cycle pulse to the privilege unit when the redirect is taken
- in_wfi  out  1  core is sleeping

Behaviour:
- Reset (async, nRST=0): state=RUN, priv_pc=0, rb_pend=0, trap_commit=0. Outputs during reset: iren=1, pc_en=1; every other output 0.
- Derived signals:
  - trap_req = valid_m & (exc_m | intr_pending | mret | sret).
  - rb_req = ROLLBACK_EN & valid_m & (ifence | sfence | csr_read).
- mem_use_stall = valid_e & valid_m & dren & rd_m!=0 & (rd_m==rs1_e | rd_m==rs2_e) & d_mem_busy.
  - Never asserted when rd_m==0.
- Stall set in RUN: mem_busy = d_mem_busy & (dren|dwen).
  - ex_mem_stall = mem_busy | fence_stall.
  - if_ex_stall = ex_mem_stall | ex_busy | mem_use_stall | i_mem_busy.
  - pc_en = !if_ex_stall.
- suppress_data = valid_m & exc_m, combinational, same cycle; a faulting store never writes.
- FSM states: RUN, DRAIN, TRAP, WFI, HALTED. Priority within RUN, highest first: halt > trap_req > wfi > rb_req > mispredict.
- RUN transitions:
  - halt & valid_m -> HALTED.
  - trap_req: latch trap_target into priv_pc; go to TRAP if !i_mem_busy, else DRAIN.
  - WFI_EN & wfi & valid_m & !intr_pending -> WFI.
  - rb_req: set rb_pend.
  - mispredict & valid_m: npc_sel=1, if_ex_flush=1, ex_mem_flush=1 in the same cycle, and pc_en=1 unless i_mem_busy.
- DRAIN:
  - suppress_iren=1, iren=0, pc_en=0, both stalls=1.
  - Leaves to TRAP on the first cycle with i_mem_busy=0.
- TRAP (exactly one cycle):
  - insert_priv_pc=1, pc_en=1, if_ex_flush=1, ex_mem_flush=1, trap_commit=1; clear rb_pend.
  - Next state RUN.
- WFI:
  - in_wfi=1, iren=0, pc_en=0, both stalls=1.
  - On intr_pending: latch trap_target and go to TRAP (no DRAIN, fetch is idle).
- HALTED: sticky until reset. iren=0, pc_en=0, both stalls=1, no flushes.
- Rollback:
  - While rb_pend and the state is RUN, rollback is held until i_mem_busy=0.
  - On that cycle: rollback=1, if_ex_flush=1, pc_en=1; rb_pend clears next cycle.
  - A trap arriving while rb_pend=1 takes precedence and clears it.
- Stall/flush interaction: a flush overrides a stall on the same register. When mem_busy=1, a mispredict or trap waits (the stage stays stalled, valid_m held) until mem_busy=0.
- Reset mid-operation returns to RUN from any state; priv_pc clears.

Test Plan:
- Load-use: dren=1, rd_m=5, rs1_e=5, d_mem_busy=1 for 3 cycles -> mem_use_stall=1, pc_en=0 for 3 cycles; then 0. With rd_m=0 -> never asserted.
- Trap with fetch busy: exc_m=1, valid_m=1, trap_target=0x8000_0100, i_mem_busy=1 for 2 cycles -> suppress_data=1 the same cycle; DRAIN 2 cycles; then one TRAP cycle with insert_priv_pc=1, priv_pc=0x8000_0100, both flushes, trap_commit=1.
- Mispredict: mispredict=1, valid_m=1, no busy -> npc_sel=1, if_ex_flush=1, ex_mem_flush=1, pc_en=1 in the same cycle.
- WFI: wfi=1, intr_pending=0 -> in_wfi=1 and iren=0 for 10 cycles. Raise intr_pending with trap_target=0x200 -> next cycle insert_priv_pc=1, priv_pc=0x200, then RUN.
- Rollback: ifence=1, valid_m=1, i_mem_busy=1 for 2 cycles -> rollback=1 and if_ex_flush=1 on the 3rd cycle only. With ROLLBACK_EN=0 -> no rollback.
- Halt then reset: halt=1 -> iren=0, pc_en=0 held for 20 cycles despite exc_m=1. nRST low mid-sequence -> RUN with iren=1, pc_en=1 and all other outputs 0 immediately.
